// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the CPU data-memory interface.
// Takes one load/store at a time over a valid/ready request channel, waits
// LATENCY extra cycles, performs a byte/half/word access into an internal
// word array and returns read data or an error over a valid/ready response
// channel.
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses return resp_err, no write.
//   undefined : low address bits are forced aligned and the access completes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | req_ready high, waiting for a request
// WAIT   | request latched, counting down latency, access on cnt == 0
// RESP   | resp_valid high, result held until resp_ready
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 64,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_maskmode,
  input  logic                  req_sext,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int AW    = IDX_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] MM_BYTE = 2'b00;
  localparam logic [1:0] MM_HALF = 2'b01;
  localparam logic [1:0] MM_WORD = 2'b10;

  logic [1:0]            state_q;
  logic [3:0]            cnt_q;
  logic                  wr_q;
  logic [AW-1:0]         addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            mm_q;
  logic                  sext_q;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic [AW-1:0]         eff_addr;
  logic                  misalign;
  logic                  access_err;
  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  do_access;

  // Only the low address bits select a word; the rest wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW];

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign do_access  = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // Alignment handling: flag misaligned accesses or force the address aligned.
  always_comb begin
    eff_addr = addr_q;
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign = ((mm_q == MM_HALF) && addr_q[0]) ||
               ((mm_q == MM_WORD) && (addr_q[1:0] != 2'b00));
`else
    if (mm_q == MM_HALF) begin
      eff_addr[0] = 1'b0;
    end else if (mm_q == MM_WORD) begin
      eff_addr[1:0] = 2'b00;
    end
`endif
  end

  assign access_err = (mm_q == 2'b11) || misalign;
  assign word_idx   = eff_addr[AW-1:2];
  assign lane       = eff_addr[1:0];
  assign cur_word   = mem[word_idx];

  // Store path: lane enables and the merged word with untouched lanes preserved.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = wdata_q;
    case (mm_q)
      MM_BYTE: begin
        byte_en   = 4'b0001 << lane;
        lane_data = {4{wdata_q[7:0]}};
      end
      MM_HALF: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
      end
      MM_WORD: begin
        byte_en   = 4'b1111;
        lane_data = wdata_q;
      end
      default: begin
        byte_en   = 4'b0000;
        lane_data = wdata_q;
      end
    endcase
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        merged[8*i +: 8] = lane_data[8*i +: 8];
      end
    end
  end

  // Load path: lane extraction plus sign/zero extension; zero for stores and errors.
  always_comb begin
    shifted  = cur_word >> {lane, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
    rdata_c  = '0;
    case (mm_q)
      MM_BYTE: rdata_c = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      MM_HALF: rdata_c = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      MM_WORD: rdata_c = cur_word;
      default: rdata_c = '0;
    endcase
    if (wr_q || access_err) begin
      rdata_c = '0;
    end
  end

  // Array write on the access edge; a reset on that edge suppresses it.
  always_ff @(posedge clk) begin
    if (rstn && do_access && wr_q && !access_err) begin
      mem[word_idx] <= merged;
    end
  end

  // Request/response FSM with latency down-counter and held response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mm_q       <= 2'b00;
      sext_q     <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr[AW-1:0];
            wdata_q <= req_wdata;
            mm_q    <= req_maskmode;
            sext_q  <= req_sext;
            cnt_q   <= 4'(LATENCY);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            resp_rdata <= rdata_c;
            resp_err   <= access_err;
            state_q    <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of load/store vectors with expected
// responses queued at accept and compared at the response, plus hand-written
// sequences for response back-pressure and reset during WAIT.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_maskmode = 2'b00;
  logic        req_sext = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  data_mem_responder #(.DATA_WIDTH(32), .NUM_WORDS(64), .LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_maskmode(req_maskmode),
    .req_sext(req_sext),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mm;
    logic        sext;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] mm, input logic sext,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.mm = mm; v.sext = sext;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // One transaction; hold > 0 keeps resp_ready low for that many cycles in RESP.
  task automatic txn(input vec_t v, input int hold, input string tag);
    logic        got;
    int          cyc;
    logic [31:0] r0;
    logic        e0;
    exp_t        e;
    @(negedge clk);
    resp_ready   = (hold == 0);
    req_write    = v.wr;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_maskmode = v.mm;
    req_sext     = v.sext;
    req_valid    = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("%s_accept", tag), {31'd0, got}, 32'd1);
    if (!got) begin
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("%s_resp_seen", tag), {31'd0, got}, 32'd1);
    chk($sformatf("%s_latency", tag), 32'(cyc - 1), 32'(LAT + 1));
    e = sb.pop_front();
    chk($sformatf("%s_rdata", tag), resp_rdata, e.rdata);
    chk($sformatf("%s_err", tag), {31'd0, resp_err}, {31'd0, e.err});
    if (hold > 0) begin
      r0 = resp_rdata;
      e0 = resp_err;
      for (int i = 0; i < hold; i++) begin
        if (i == 1) begin
          req_write    = 1'b1;
          req_addr     = 32'h10;
          req_wdata    = 32'hBAD0BAD0;
          req_maskmode = 2'b10;
          req_valid    = 1'b1;
        end
        @(negedge clk);
        req_valid = 1'b0;
        chk($sformatf("%s_hold%0d_valid", tag, i), {31'd0, resp_valid}, 32'd1);
        chk($sformatf("%s_hold%0d_rdata", tag, i), resp_rdata, r0);
        chk($sformatf("%s_hold%0d_err", tag, i), {31'd0, resp_err}, {31'd0, e0});
        chk($sformatf("%s_hold%0d_req_ready", tag, i), {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("%s_after_valid", tag), {31'd0, resp_valid}, 32'd0);
    chk($sformatf("%s_after_ready", tag), {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] w10_final;
  int          stray;

  initial begin
`ifdef DMEM_MISALIGN_CHECK_EN
    w10_final = 32'h7EC38000;
`else
    w10_final = 32'h12345678;
`endif
    // wr, addr, wdata, mm, sext, exp_rdata, exp_err
    tbl.push_back(mk(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 32'h10, 32'h0,        2'b10, 0, 32'h0, 0));
    tbl.push_back(mk(1, 32'h11, 32'h00000080, 2'b00, 0, 32'h0, 0));
    tbl.push_back(mk(0, 32'h11, 32'h0,        2'b00, 1, 32'hFFFFFF80, 0));
    tbl.push_back(mk(0, 32'h11, 32'h0,        2'b00, 0, 32'h00000080, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        2'b10, 0, 32'h00008000, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        2'b01, 1, 32'hFFFF8000, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        2'b01, 0, 32'h00008000, 0));
    tbl.push_back(mk(1, 32'h12, 32'h1234A5C3, 2'b01, 0, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        2'b10, 0, 32'hA5C38000, 0));
    tbl.push_back(mk(1, 32'h13, 32'hFFFFFF7E, 2'b00, 0, 32'h0, 0));
    tbl.push_back(mk(0, 32'h10, 32'h0,        2'b10, 1, 32'h7EC38000, 0));
    tbl.push_back(mk(0, 32'h13, 32'h0,        2'b00, 1, 32'h0000007E, 0));
    tbl.push_back(mk(0, 32'h12, 32'h0,        2'b00, 1, 32'hFFFFFFC3, 0));
`ifdef DMEM_MISALIGN_CHECK_EN
    tbl.push_back(mk(0, 32'h13, 32'h0,        2'b01, 0, 32'h0, 1));
    tbl.push_back(mk(1, 32'h12, 32'h12345678, 2'b10, 0, 32'h0, 1));
`else
    tbl.push_back(mk(0, 32'h13, 32'h0,        2'b01, 0, 32'h00007EC3, 0));
    tbl.push_back(mk(1, 32'h12, 32'h12345678, 2'b10, 0, 32'h0, 0));
`endif
    tbl.push_back(mk(0, 32'h10, 32'h0,        2'b10, 0, w10_final, 0));
    tbl.push_back(mk(1, 32'h20, 32'h11223344, 2'b10, 0, 32'h0, 0));
    tbl.push_back(mk(1, 32'h20, 32'hFFFFFFFF, 2'b11, 0, 32'h0, 1));
    tbl.push_back(mk(0, 32'h20, 32'h0,        2'b10, 1, 32'h11223344, 0));
    tbl.push_back(mk(0, 32'h20, 32'h0,        2'b11, 0, 32'h0, 1));
    tbl.push_back(mk(1, 32'h124, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0));
    tbl.push_back(mk(0, 32'h24, 32'h0,        2'b10, 0, 32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 32'hFFFFFF24, 32'h0,  2'b10, 0, 32'hCAFEF00D, 0));

    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rstn = 1'b1;

    foreach (tbl[k]) txn(tbl[k], 0, $sformatf("vec%0d", k));

    // Back-pressure in RESP with an ignored request pulse, then confirm no write
    txn(mk(0, 32'h10, 32'h0, 2'b10, 0, w10_final, 0), 5, "hold");
    txn(mk(0, 32'h10, 32'h0, 2'b10, 0, w10_final, 0), 0, "hold_check");

    // Reset during WAIT of a store
    txn(mk(1, 32'h30, 32'h55555555, 2'b10, 0, 32'h0, 0), 0, "pre30");
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hAAAAAAAA;
    req_maskmode = 2'b10; req_sext = 1'b0; req_valid = 1'b1;
    chk("rstwait_ready_before", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rstwait_in_wait", {31'd0, req_ready}, 32'd0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk("rstwait_req_ready", {31'd0, req_ready}, 32'd1);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    chk("rstwait_no_resp", 32'(stray), 32'd0);
    txn(mk(0, 32'h30, 32'h0, 2'b10, 0, 32'h55555555, 0), 0, "post30");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
